// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sweep sequencer.
package counter_pkg;

  localparam int CNT_W  = 8;
  localparam int STEP_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN_UP = 3'd2,
    RUN_DN = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_CFGERR = 2'b01,
    ST_ABORT  = 2'b10
  } status_t;

  // A sweep that cannot make progress or would start above its ceiling is rejected up front.
  function automatic logic cfg_invalid(
    input logic [STEP_W-1:0] start_v,
    input logic [STEP_W-1:0] step_v,
    input logic [CNT_W-1:0]  limit_v,
    input logic [3:0]        passes_v
  );
    return (step_v == 4'd0) || (passes_v == 4'd0) || (limit_v < {4'd0, start_v});
  endfunction

endpackage

// File: rtl/counter_seq_if.sv
// Control/readback bus between the sweep sequencer and the 8-bit up/down counter.
interface counter_seq_if;
  import counter_pkg::*;

  logic              cnt_enable;
  logic              cnt_preload;
  logic              cnt_updn;
  logic [STEP_W-1:0] cnt_pl_data;
  logic [STEP_W-1:0] cnt_incr;
  logic [CNT_W-1:0]  cnt_value;

  modport master (
    output cnt_enable,
    output cnt_preload,
    output cnt_updn,
    output cnt_pl_data,
    output cnt_incr,
    input  cnt_value
  );

  modport slave (
    input  cnt_enable,
    input  cnt_preload,
    input  cnt_updn,
    input  cnt_pl_data,
    input  cnt_incr,
    output cnt_value
  );

endinterface

// File: rtl/counter_seq_term.sv
// Step-allowed decision for one counter move, evaluated in 9 bits so the count can never wrap.
module counter_seq_term
  import counter_pkg::*;
(
  input  logic [CNT_W-1:0]  value,
  input  logic [STEP_W-1:0] step,
  input  logic [STEP_W-1:0] start,
  input  logic [CNT_W-1:0]  limit,
  input  logic              dir_up,
  output logic              step_ok
);

  logic [CNT_W:0] up_sum_s;
  logic [CNT_W:0] dn_floor_s;

  // Up: next value must stay within limit; down: next value must stay at or above start.
  always_comb begin
    up_sum_s   = {1'b0, value} + {5'd0, step};
    dn_floor_s = {5'd0, start} + {5'd0, step};
    if (dir_up) begin
      step_ok = (up_sum_s <= {1'b0, limit});
    end else begin
      step_ok = ({1'b0, value} >= dn_floor_s);
    end
  end

endmodule

// File: rtl/counter_seq.sv
// Sweep sequencer: owns the counter controls and runs one-shot or ping-pong multi-pass sweeps.
module counter_seq
  import counter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] cfg_start,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [CNT_W-1:0]  cfg_limit,
  input  logic [3:0]        cfg_passes,
  input  logic              cfg_pingpong,
  counter_seq_if.master     cnt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [3:0]        pass_cnt
);

  state_t            state_r;
  state_t            next_state_s;
  logic [STEP_W-1:0] start_r;
  logic [STEP_W-1:0] step_r;
  logic [CNT_W-1:0]  limit_r;
  logic [3:0]        passes_r;
  logic              pingpong_r;
  status_t           status_r;
  logic [3:0]        pass_cnt_r;

  logic              accept_s;
  logic              bad_cfg_s;
  logic              step_ok_s;
  logic              final_pass_s;
  logic              pass_end_s;
  logic              abort_stop_s;
  logic              enable_s;
  logic              preload_s;
  logic              updn_s;

  assign accept_s     = (state_r == IDLE) && start && !abort;
  assign bad_cfg_s    = cfg_invalid(cfg_start, cfg_step, cfg_limit, cfg_passes);
  assign final_pass_s = ((pass_cnt_r + 4'd1) == passes_r);

  counter_seq_term u_term (
    .value   (cnt.cnt_value),
    .step    (step_r),
    .start   (start_r),
    .limit   (limit_r),
    .dir_up  (state_r == RUN_UP),
    .step_ok (step_ok_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and counter control decode; abort suppresses any counter motion in the same cycle.
  always_comb begin
    next_state_s = state_r;
    enable_s     = 1'b0;
    preload_s    = 1'b0;
    updn_s       = 1'b0;
    pass_end_s   = 1'b0;
    abort_stop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = bad_cfg_s ? DONE : LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          abort_stop_s = 1'b1;
          next_state_s = DONE;
        end else begin
          preload_s    = 1'b1;
          next_state_s = RUN_UP;
        end
      end
      RUN_UP, RUN_DN: begin
        updn_s = (state_r == RUN_UP);
        if (abort) begin
          abort_stop_s = 1'b1;
          next_state_s = DONE;
        end else if (step_ok_s) begin
          enable_s = 1'b1;
        end else begin
          pass_end_s = 1'b1;
          if (final_pass_s) begin
            next_state_s = DONE;
          end else if (pingpong_r) begin
            next_state_s = (state_r == RUN_UP) ? RUN_DN : RUN_UP;
          end else begin
            next_state_s = LOAD;
          end
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Shadow copy of the configuration, captured only when a sweep is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_r    <= 4'd0;
      step_r     <= 4'd0;
      limit_r    <= 8'd0;
      passes_r   <= 4'd0;
      pingpong_r <= 1'b0;
    end else if (accept_s) begin
      start_r    <= cfg_start;
      step_r     <= cfg_step;
      limit_r    <= cfg_limit;
      passes_r   <= cfg_passes;
      pingpong_r <= cfg_pingpong;
    end
  end

  // Status and pass count: cleared on accept, then held through DONE until the next accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_r   <= ST_OK;
      pass_cnt_r <= 4'd0;
    end else if (accept_s) begin
      status_r   <= bad_cfg_s ? ST_CFGERR : ST_OK;
      pass_cnt_r <= 4'd0;
    end else if (abort_stop_s) begin
      status_r   <= ST_ABORT;
    end else if (pass_end_s) begin
      pass_cnt_r <= pass_cnt_r + 4'd1;
    end
  end

  assign cnt.cnt_enable  = enable_s;
  assign cnt.cnt_preload = preload_s;
  assign cnt.cnt_updn    = updn_s;
  assign cnt.cnt_pl_data = start_r;
  assign cnt.cnt_incr    = step_r;

  assign busy     = (state_r == LOAD) || (state_r == RUN_UP) || (state_r == RUN_DN);
  assign done     = (state_r == DONE);
  assign status   = status_r;
  assign pass_cnt = pass_cnt_r;

endmodule
